tile_shuffler: RTL and testbench

//  Generates a fresh random tile order for the game board: a uniform-ish

---
 rtl/tile_shuffler_if.sv | 27 ++
 rtl/tile_shuffler.sv | 164 ++++++++++++++++
 tb/tb_tile_shuffler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_shuffler_if.sv
// Bus between game control / board logic and the tile shuffler.
// The shuffler sits on the slave side; control and display logic use the master side.
interface tile_shuffler_if #(
  parameter int NUM_TILES = 24,
  parameter int POS_W     = 6,
  parameter int LFSR_W    = 16
);
  logic                         seed_load;
  logic [LFSR_W-1:0]            seed_in;
  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         order_valid;
  logic [NUM_TILES*POS_W-1:0]   order_flat;
  logic [POS_W-1:0]             rd_idx;
  logic [POS_W-1:0]             rd_pos;

  modport master (
    output seed_load, seed_in, start, rd_idx,
    input  busy, done, order_valid, order_flat, rd_pos
  );

  modport slave (
    input  seed_load, seed_in, start, rd_idx,
    output busy, done, order_valid, order_flat, rd_pos
  );
endinterface

// File: rtl/tile_shuffler.sv
// Random tile order generator: Galois-LFSR driven Fisher-Yates shuffle with
// rejection sampling, producing a fresh permutation of NUM_TILES positions.
module tile_shuffler #(
  parameter int                NUM_TILES = 24,
  parameter int                POS_W     = 6,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst_n,
  tile_shuffler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DRAW,
    SWAP,
    FIN
  } state_e;

  state_e                state_q, state_d;
  logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]     lfsrStep;
  logic [POS_W-1:0]      slot_q [NUM_TILES];
  logic [POS_W-1:0]      slot_d [NUM_TILES];
  logic [POS_W-1:0]      tileIdx_q, tileIdx_d;
  logic [POS_W-1:0]      swapIdx_q, swapIdx_d;
  logic                  busy_q, busy_d;
  logic                  orderValid_q, orderValid_d;
  logic                  donePulse;
  logic [POS_W-1:0]      drawVal;
  logic [NUM_TILES*POS_W-1:0] orderFlat;
  logic [POS_W-1:0]      rdPos;

  // The LFSR free-runs in every state so the moment the player presses
  // start changes the outcome; a zero seed would lock it up, so map it to SEED.
  always_comb begin
    lfsrStep = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsrStep = lfsrStep ^ LFSR_TAPS;
    end
    lfsr_d = lfsrStep;
    if (bus.seed_load) begin
      lfsr_d = (bus.seed_in == '0) ? SEED : bus.seed_in;
    end
  end

  assign drawVal = lfsr_q[POS_W-1:0];

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    tileIdx_d    = tileIdx_q;
    swapIdx_d    = swapIdx_q;
    busy_d       = busy_q;
    orderValid_d = orderValid_q;
    donePulse    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = INIT;
          busy_d       = 1'b1;
          orderValid_d = 1'b0;
        end
      end

      INIT: begin
        for (int k = 0; k < NUM_TILES; k++) begin
          slot_d[k] = POS_W'(k);
        end
        tileIdx_d = POS_W'(NUM_TILES - 1);
        state_d   = DRAW;
      end

      // Draws above the current index are thrown away rather than folded,
      // which keeps the distribution free of modulo bias.
      DRAW: begin
        if (drawVal <= tileIdx_q) begin
          swapIdx_d = drawVal;
          state_d   = SWAP;
        end
      end

      SWAP: begin
        slot_d[tileIdx_q] = slot_q[swapIdx_q];
        slot_d[swapIdx_q] = slot_q[tileIdx_q];
        if (tileIdx_q == POS_W'(1)) begin
          state_d = FIN;
        end else begin
          tileIdx_d = tileIdx_q - POS_W'(1);
          state_d   = DRAW;
        end
      end

      FIN: begin
        donePulse    = 1'b1;
        orderValid_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED;
      tileIdx_q    <= '0;
      swapIdx_q    <= '0;
      busy_q       <= 1'b0;
      orderValid_q <= 1'b0;
      for (int k = 0; k < NUM_TILES; k++) begin
        slot_q[k] <= POS_W'(k);
      end
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      tileIdx_q    <= tileIdx_d;
      swapIdx_q    <= swapIdx_d;
      busy_q       <= busy_d;
      orderValid_q <= orderValid_d;
      slot_q       <= slot_d;
    end
  end

  always_comb begin
    orderFlat = '0;
    for (int k = 0; k < NUM_TILES; k++) begin
      orderFlat[k*POS_W +: POS_W] = slot_q[k];
    end
  end

  // Out-of-range read indices return 0 rather than aliasing onto a real slot.
  always_comb begin
    rdPos = '0;
    if (int'(bus.rd_idx) < NUM_TILES) begin
      rdPos = slot_q[bus.rd_idx];
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = donePulse;
  assign bus.order_valid = orderValid_q;
  assign bus.order_flat  = orderFlat;
  assign bus.rd_pos      = rdPos;

  property pBusyValidExclusive;
    @(posedge clk) disable iff (!rst_n) !(busy_q && orderValid_q);
  endproperty
  assert property (pBusyValidExclusive);

  property pDoneWhileBusy;
    @(posedge clk) disable iff (!rst_n) donePulse |-> busy_q;
  endproperty
  assert property (pDoneWhileBusy);

endmodule

// File: tb/tb_tile_shuffler.sv
// Scoreboard bench for tile_shuffler: a 24-tile instance and a 4-tile instance,
// expected orders and latencies come from an algorithmic shuffle model.
module tb_tile_shuffler;

  localparam int N_A = 24;
  localparam int P_A = 6;
  localparam int N_B = 4;
  localparam int P_B = 2;
  localparam int LW  = 16;

  typedef struct packed {
    logic [23:0][5:0] order;
    int               lat;
    int               startCyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qA[$];
  exp_t qB[$];
  bit   activeA = 1'b0;
  bit   activeB = 1'b0;
  logic [255:0] seenOrders = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  tile_shuffler_if #(.NUM_TILES(N_A), .POS_W(P_A), .LFSR_W(LW)) busA ();
  tile_shuffler_if #(.NUM_TILES(N_B), .POS_W(P_B), .LFSR_W(LW)) busB ();

  tile_shuffler #(.NUM_TILES(N_A), .POS_W(P_A), .LFSR_W(LW)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  tile_shuffler #(.NUM_TILES(N_B), .POS_W(P_B), .LFSR_W(LW)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] lfsrAdv(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Fisher-Yates as seen cycle by cycle: one INIT cycle, then each DRAW cycle
  // consumes one LFSR value and each accepted draw is followed by a SWAP cycle.
  function automatic exp_t model(input int n, input int posw, input logic [15:0] seed, input int gap);
    exp_t        e;
    logic [15:0] l;
    int          ord [24];
    int          r, j, tmp, d, guard;
    e = '0;
    d = 0;
    l = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int g = 0; g < gap; g++) l = lfsrAdv(l);
    for (int k = 0; k < 24; k++) ord[k] = k;
    l = lfsrAdv(l);
    for (int i = n - 1; i >= 1; i--) begin
      r = int'(l) & ((1 << posw) - 1);
      d++;
      guard = 0;
      while (r > i && guard < 10000) begin
        l = lfsrAdv(l);
        r = int'(l) & ((1 << posw) - 1);
        d++;
        guard++;
      end
      j = r;
      tmp = ord[i];
      ord[i] = ord[j];
      ord[j] = tmp;
      l = lfsrAdv(lfsrAdv(l));
    end
    for (int k = 0; k < 24; k++) e.order[k] = ord[k][5:0];
    e.lat = d + n;
    return e;
  endfunction

  task automatic checkResult(input string tag, input logic [143:0] flat, input int n, input int posw,
                             input exp_t e, input int rdPos, input int rdIdx);
    logic [63:0] mask;
    int          v;
    mask = '0;
    for (int k = 0; k < n; k++) begin
      v = int'(flat >> (k * posw)) & ((1 << posw) - 1);
      if (v < n) mask[v] = 1'b1;
      checkOutput($sformatf("%s_slot%0d", tag, k), v, int'(e.order[k]));
    end
    checkOutput({tag, "_permutation"}, $countones(mask), n);
    checkOutput({tag, "_latency"}, cyc - e.startCyc, e.lat);
    checkOutput({tag, "_rd_pos"}, rdPos, int'(e.order[rdIdx]));
  endtask

  task automatic driveSeed(input int sel, input logic load, input logic [15:0] seed);
    if (sel == 0) begin
      busA.seed_load = load;
      busA.seed_in   = seed;
    end else begin
      busB.seed_load = load;
      busB.seed_in   = seed;
    end
  endtask

  task automatic driveStart(input int sel, input logic s);
    if (sel == 0) busA.start = s;
    else          busB.start = s;
  endtask

  // Loads a seed, issues start `gap` cycles later and queues the expected result.
  task automatic applyStimulus(input int sel, input logic [15:0] seed, input int gap);
    exp_t e;
    @(negedge clk);
    driveSeed(sel, 1'b1, seed);
    if (gap > 0) begin
      @(negedge clk);
      driveSeed(sel, 1'b0, seed);
      for (int g = 1; g < gap; g++) @(negedge clk);
    end
    driveStart(sel, 1'b1);
    e = (sel == 0) ? model(N_A, P_A, seed, gap) : model(N_B, P_B, seed, gap);
    e.startCyc = cyc + 1;
    if (sel == 0) qA.push_back(e);
    else          qB.push_back(e);
    @(negedge clk);
    driveStart(sel, 1'b0);
    driveSeed(sel, 1'b0, seed);
  endtask

  function automatic bit pending(input int sel);
    if (sel == 0) return (qA.size() != 0) || activeA;
    return (qB.size() != 0) || activeB;
  endfunction

  task automatic waitIdle(input int sel, input int budget);
    int n = 0;
    while (pending(sel) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (pending(sel)) begin
      checkOutput((sel == 0) ? "A_done_timeout" : "B_done_timeout", 0, 1);
      if (sel == 0) qA.delete();
      else          qB.delete();
    end
  endtask

  initial begin : monitorA
    exp_t e;
    int   stable;
    forever begin
      @(negedge clk);
      if (rst_n && busA.done) begin
        activeA = 1'b1;
        if (qA.size() == 0) begin
          checkOutput("A_unexpected_done", 1, 0);
        end else begin
          e = qA.pop_front();
          checkResult("A", 144'(busA.order_flat), N_A, P_A, e, int'(busA.rd_pos), int'(busA.rd_idx));
          @(negedge clk);
          checkOutput("A_busy_after_done", int'(busA.busy), 0);
          checkOutput("A_valid_after_done", int'(busA.order_valid), 1);
          checkOutput("A_done_single_cycle", int'(busA.done), 0);
          stable = 0;
          for (int k = 0; k < N_A; k++)
            if (busA.order_flat[k*P_A +: P_A] == e.order[k]) stable++;
          checkOutput("A_order_stable", stable, N_A);
        end
        activeA = 1'b0;
      end
    end
  end

  initial begin : monitorB
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && busB.done) begin
        activeB = 1'b1;
        if (qB.size() == 0) begin
          checkOutput("B_unexpected_done", 1, 0);
        end else begin
          e = qB.pop_front();
          checkResult("B", 144'(busB.order_flat), N_B, P_B, e, int'(busB.rd_pos), int'(busB.rd_idx));
          seenOrders[busB.order_flat] = 1'b1;
          @(negedge clk);
          checkOutput("B_busy_after_done", int'(busB.busy), 0);
          checkOutput("B_valid_after_done", int'(busB.order_valid), 1);
        end
        activeB = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : stimulus
    busA.seed_load = 1'b0; busA.seed_in = '0; busA.start = 1'b0; busA.rd_idx = 6'd5;
    busB.seed_load = 1'b0; busB.seed_in = '0; busB.start = 1'b0; busB.rd_idx = 2'd3;

    // Reset state: identity order, idle flags, combinational read port.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", int'(busA.busy), 0);
    checkOutput("reset_done", int'(busA.done), 0);
    checkOutput("reset_order_valid", int'(busA.order_valid), 0);
    checkOutput("reset_rd_pos5", int'(busA.rd_pos), 5);
    checkOutput("reset_B_rd_pos3", int'(busB.rd_pos), 3);
    for (int k = 0; k < N_A; k++)
      checkOutput($sformatf("reset_slot%0d", k), int'(busA.order_flat[k*P_A +: P_A]), k);
    busA.rd_idx = 6'd30;
    #1;
    checkOutput("rd_pos_out_of_range", int'(busA.rd_pos), 0);
    busA.rd_idx = 6'd5;

    $display("[TB] seeded shuffles on 24-tile instance");
    applyStimulus(0, 16'h1234, 1);
    waitIdle(0, 2000);
    applyStimulus(0, 16'h1234, 1);
    waitIdle(0, 2000);
    applyStimulus(0, 16'h4321, 1);
    waitIdle(0, 2000);
    applyStimulus(0, 16'h1234, 0);
    waitIdle(0, 2000);

    $display("[TB] zero seed and start while busy");
    applyStimulus(0, 16'h0000, 2);
    repeat (8) @(negedge clk);
    checkOutput("A_busy_mid_shuffle", int'(busA.busy), 1);
    busA.start = 1'b1;
    @(negedge clk);
    busA.start = 1'b0;
    waitIdle(0, 2000);
    repeat (80) @(negedge clk);

    $display("[TB] reset during shuffle");
    applyStimulus(0, 16'h5A5A, 0);
    repeat (15) @(negedge clk);
    checkOutput("A_busy_before_reset", int'(busA.busy), 1);
    #2;
    rst_n = 1'b0;
    qA.delete();
    #1;
    checkOutput("A_busy_in_reset", int'(busA.busy), 0);
    checkOutput("A_done_in_reset", int'(busA.done), 0);
    for (int k = 0; k < N_A; k++)
      checkOutput($sformatf("A_reset_slot%0d", k), int'(busA.order_flat[k*P_A +: P_A]), k);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("A_valid_after_reset", int'(busA.order_valid), 0);
    applyStimulus(0, 16'hBEEF, 0);
    waitIdle(0, 2000);

    $display("[TB] 1000 shuffles on 4-tile instance");
    for (int n = 0; n < 1000; n++) begin
      applyStimulus(1, 16'($urandom_range(1, 65535)), int'($urandom_range(0, 2)));
      waitIdle(1, 500);
    end
    checkOutput("B_order_coverage", $countones(seenOrders), 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
